multicore_interrupt_ctrl: RTL and testbench

Parametrised successor to the two-core interrupt controller. It accepts interrupt triggers and vector PCs from NUM_SOURCES requesters. Each trigger is routed to NUM_CORES cores through per-core enable masks, and pending requests are held until the target core is not stalled. One interrupt is delivered per core at a time, with fixed priority and end-of-interrupt (EOI) acknowledgement. It sits between the cores' interrupt_PC_out/trigger_out and interrupt_PC_in/trigger_in ports in the top level.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_core_port.sv | 84 ++++++++
 rtl/multicore_interrupt_ctrl.sv | 121 ++++++++++++
 tb/tb_multicore_interrupt_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types for the multicore interrupt controller: per-core FSM state
// encoding and the index-width helper used to size source/core index fields.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        SERVICE = 2'd2
    } core_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_core_port.sv
// One delivery port per core: lowest-index priority encoder over the core's
// pending bits, the IDLE/DELIVER/SERVICE FSM with registered outputs, and the
// one-hot pending-clear issued while in DELIVER.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no interrupt in service; waits for a pending bit and no stall
//   DELIVER | one-cycle irq_trigger pulse; clears the delivered pending bit
//   SERVICE | handler running; waits for eoi
module intc_core_port
    import intc_pkg::*;
#(
    parameter int NUM_SOURCES  = 8,
    parameter int ADDRESS_BITS = 32,
    parameter int SRC_BITS     = idx_bits(NUM_SOURCES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SOURCES-1:0]  pend,
    input  logic                    stall,
    input  logic                    eoi,
    input  logic [ADDRESS_BITS-1:0] sel_pc,
    output logic [SRC_BITS-1:0]     sel,
    output logic [NUM_SOURCES-1:0]  clr,
    output logic                    irq_trigger,
    output logic [ADDRESS_BITS-1:0] irq_pc,
    output logic [SRC_BITS-1:0]     irq_src,
    output logic                    busy
);

    core_state_t state;

    // Lowest set pending index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        sel = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (pend[i]) sel = SRC_BITS'(i);
        end
    end

    // The source latched at IDLE->DELIVER is the one cleared during DELIVER.
    always_comb begin
        clr = '0;
        if (state == DELIVER) clr[irq_src] = 1'b1;
    end

    // Core delivery FSM; outputs are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            irq_trigger <= 1'b0;
            irq_pc      <= '0;
            irq_src     <= '0;
            busy        <= 1'b0;
        end else begin
            irq_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pend && !stall) begin
                        state       <= DELIVER;
                        irq_trigger <= 1'b1;
                        irq_pc      <= sel_pc;
                        irq_src     <= sel;
                        busy        <= 1'b1;
                    end
                end
                DELIVER: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicore_interrupt_ctrl.sv
// Multicore interrupt controller: routes NUM_SOURCES triggers to NUM_CORES
// cores through per-core enable masks, holds per-(core, source) pending bits
// and delivers one interrupt per core at a time with fixed priority and EOI.
// Optional build macro INTC_OVERFLOW_CNT_EN adds saturating per-source counts
// of triggers that arrive while that source is already pending on some core.
module multicore_interrupt_ctrl
    import intc_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int NUM_SOURCES  = 8,
    parameter int ADDRESS_BITS = 32,
    parameter int SRC_BITS     = idx_bits(NUM_SOURCES),
    parameter int CORE_BITS    = idx_bits(NUM_CORES)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_SOURCES-1:0]            src_trigger,
    input  logic [NUM_SOURCES*ADDRESS_BITS-1:0] src_pc,
    input  logic [NUM_CORES-1:0]              stall,
    input  logic [NUM_CORES-1:0]              eoi,
    input  logic                              cfg_we,
    input  logic [CORE_BITS-1:0]              cfg_core,
    input  logic [NUM_SOURCES-1:0]            cfg_mask,
    output logic [NUM_CORES-1:0]              irq_trigger,
    output logic [NUM_CORES*ADDRESS_BITS-1:0] irq_pc,
    output logic [NUM_CORES*SRC_BITS-1:0]     irq_src,
    output logic [NUM_CORES-1:0]              busy
`ifdef INTC_OVERFLOW_CNT_EN
    ,
    output logic [NUM_SOURCES*8-1:0]          ovf_count
`endif
);

    logic [ADDRESS_BITS-1:0] vec [NUM_SOURCES];

`ifdef INTC_OVERFLOW_CNT_EN
    logic [NUM_CORES*NUM_SOURCES-1:0] pend_flat;
    logic [NUM_SOURCES-1:0]           pend_any;
`endif

    // Vector capture: the most recent trigger's PC always replaces the old one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SOURCES; s++) vec[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SOURCES; s++) begin
                if (src_trigger[s]) vec[s] <= src_pc[s*ADDRESS_BITS +: ADDRESS_BITS];
            end
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        logic [NUM_SOURCES-1:0]  mask;
        logic [NUM_SOURCES-1:0]  pend;
        logic [NUM_SOURCES-1:0]  clr;
        logic [SRC_BITS-1:0]     sel;
        logic [ADDRESS_BITS-1:0] sel_pc;

        // Mask write; out-of-range cfg_core values match no core and are dropped.
        always_ff @(posedge clock or posedge reset) begin
            if (reset)                                   mask <= '1;
            else if (cfg_we && cfg_core == CORE_BITS'(c)) mask <= cfg_mask;
        end

        // Pending update; a same-cycle trigger beats the delivery clear.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) pend <= '0;
            else       pend <= (pend & ~clr) | (src_trigger & mask);
        end

        assign sel_pc = vec[sel];

`ifdef INTC_OVERFLOW_CNT_EN
        assign pend_flat[c*NUM_SOURCES +: NUM_SOURCES] = pend;
`endif

        intc_core_port #(
            .NUM_SOURCES (NUM_SOURCES),
            .ADDRESS_BITS(ADDRESS_BITS),
            .SRC_BITS    (SRC_BITS)
        ) u_port (
            .clock      (clock),
            .reset      (reset),
            .pend       (pend),
            .stall      (stall[c]),
            .eoi        (eoi[c]),
            .sel_pc     (sel_pc),
            .sel        (sel),
            .clr        (clr),
            .irq_trigger(irq_trigger[c]),
            .irq_pc     (irq_pc[c*ADDRESS_BITS +: ADDRESS_BITS]),
            .irq_src    (irq_src[c*SRC_BITS +: SRC_BITS]),
            .busy       (busy[c])
        );
    end

`ifdef INTC_OVERFLOW_CNT_EN
    // A source counts as already pending if any core still holds it.
    always_comb begin
        pend_any = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int s = 0; s < NUM_SOURCES; s++) begin
                pend_any[s] = pend_any[s] | pend_flat[c*NUM_SOURCES + s];
            end
        end
    end

    // Saturating overflow counters, one byte per source.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else begin
            for (int s = 0; s < NUM_SOURCES; s++) begin
                if (src_trigger[s] && pend_any[s] && ovf_count[s*8 +: 8] != 8'hFF)
                    ovf_count[s*8 +: 8] <= ovf_count[s*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicore_interrupt_ctrl.sv
// Directed bench for multicore_interrupt_ctrl with default parameters
// (4 cores, 8 sources, 32-bit PCs). Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_multicore_interrupt_ctrl;

    localparam int NC = 4;
    localparam int NS = 8;
    localparam int AB = 32;
    localparam int SB = 3;
    localparam int CB = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NS-1:0]     src_trigger;
    logic [NS*AB-1:0]  src_pc;
    logic [NC-1:0]     stall;
    logic [NC-1:0]     eoi;
    logic              cfg_we;
    logic [CB-1:0]     cfg_core;
    logic [NS-1:0]     cfg_mask;
    logic [NC-1:0]     irq_trigger;
    logic [NC*AB-1:0]  irq_pc;
    logic [NC*SB-1:0]  irq_src;
    logic [NC-1:0]     busy;
`ifdef INTC_OVERFLOW_CNT_EN
    logic [NS*8-1:0]   ovf_count;
`endif

    int errors = 0;
    int checks = 0;

    multicore_interrupt_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .src_trigger(src_trigger),
        .src_pc     (src_pc),
        .stall      (stall),
        .eoi        (eoi),
        .cfg_we     (cfg_we),
        .cfg_core   (cfg_core),
        .cfg_mask   (cfg_mask),
        .irq_trigger(irq_trigger),
        .irq_pc     (irq_pc),
        .irq_src    (irq_src),
        .busy       (busy)
`ifdef INTC_OVERFLOW_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input int s, input logic [AB-1:0] pc);
        src_pc[s*AB +: AB] = pc;
    endtask

    initial begin
        reset = 1'b1; src_trigger = '0; src_pc = '0; stall = '0; eoi = '0;
        cfg_we = 1'b0; cfg_core = '0; cfg_mask = '0;
        tick(); tick();
        chk("rst_busy", busy, 4'h0);
        chk("rst_trig", irq_trigger, 4'h0);
        chk("rst_pc", irq_pc, 128'h0);
        chk("rst_src", irq_src, 12'h0);
        reset = 1'b0;
        tick();

        // Single source 3 to all cores, two-cycle latency
        src_trigger = 8'h08; set_pc(3, 32'h100);
        tick();
        src_trigger = '0;
        chk("t1_lat_n1", irq_trigger, 4'h0);
        tick();
        chk("t1_trig", irq_trigger, 4'hF);
        chk("t1_pc", irq_pc, {4{32'h100}});
        chk("t1_src", irq_src, 12'h6DB);
        chk("t1_busy", busy, 4'hF);
        tick();
        chk("t1_pulse_end", irq_trigger, 4'h0);
        chk("t1_service", busy, 4'hF);
        eoi = 4'b0011;
        tick();
        eoi = '0;
        chk("t1_eoi_lo", busy, 4'b1100);
        chk("t1_pc_held", irq_pc, {4{32'h100}});
        eoi = 4'b1100;
        tick();
        eoi = '0;
        chk("t1_eoi_hi", busy, 4'h0);

        // Sources 1 and 5 together: 1 first, 5 two cycles after eoi
        src_trigger = 8'h22; set_pc(1, 32'h110); set_pc(5, 32'h500);
        tick();
        src_trigger = '0;
        tick();
        chk("t2_first_trig", irq_trigger, 4'hF);
        chk("t2_first_src", irq_src, 12'h249);
        chk("t2_first_pc", irq_pc, {4{32'h110}});
        tick();
        eoi = 4'hF;
        tick();
        eoi = '0;
        chk("t2_idle_busy", busy, 4'h0);
        chk("t2_idle_trig", irq_trigger, 4'h0);
        tick();
        chk("t2_second_trig", irq_trigger, 4'hF);
        chk("t2_second_src", irq_src, 12'hB6D);
        chk("t2_second_pc", irq_pc, {4{32'h500}});
        tick();
        eoi = 4'hF;
        tick();
        eoi = '0;

        // Core 2 mask = 0x01; source 4 must skip core 2
        cfg_we = 1'b1; cfg_core = 2'd2; cfg_mask = 8'h01;
        tick();
        cfg_we = 1'b0;
        src_trigger = 8'h10; set_pc(4, 32'h400);
        tick();
        src_trigger = '0;
        tick();
        chk("t3_trig", irq_trigger, 4'b1011);
        chk("t3_busy", busy, 4'b1011);
        chk("t3_pc_core0", irq_pc[31:0], 32'h400);
        tick();
        eoi = 4'hF;
        tick();
        eoi = '0;
        tick(); tick();
        chk("t3_core2_quiet_trig", irq_trigger, 4'h0);
        chk("t3_core2_quiet_busy", busy, 4'h0);

        // Stall core 1 for ten cycles across a source-2 trigger (core 2 still masked)
        stall = 4'b0010;
        tick();
        tick();
        src_trigger = 8'h04; set_pc(2, 32'h200);
        tick();
        src_trigger = '0;
        tick();
        chk("t4_others_trig", irq_trigger, 4'b1001);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_stalled_trig", irq_trigger, 4'h0);
        chk("t4_stalled_busy", busy, 4'b1001);
        stall = '0;
        tick();
        chk("t4_release_trig", irq_trigger, 4'b0010);
        chk("t4_release_src", irq_src[5:3], 3'd2);
        chk("t4_release_pc", irq_pc[63:32], 32'h200);
        tick();
        eoi = 4'hF;
        tick();
        eoi = '0;
        chk("t4_done_busy", busy, 4'h0);

        // Source 0 triggered twice before delivery: latest PC, single delivery
        stall = 4'hF;
        src_trigger = 8'h01; set_pc(0, 32'h40);
        tick();
        set_pc(0, 32'h80);
        tick();
        src_trigger = '0;
        stall = '0;
        tick();
        chk("t5_trig", irq_trigger, 4'hF);
        chk("t5_pc", irq_pc, {4{32'h80}});
        chk("t5_src", irq_src, 12'h0);
`ifdef INTC_OVERFLOW_CNT_EN
        chk("t5_ovf", ovf_count, 64'h1);
`endif
        tick();
        eoi = 4'hF;
        tick();
        eoi = '0;
        tick(); tick();
        chk("t5_single_trig", irq_trigger, 4'h0);
        chk("t5_single_busy", busy, 4'h0);

        // Reset during SERVICE with the source re-pended; nothing after release
        src_trigger = 8'h40; set_pc(6, 32'h600);
        tick();
        src_trigger = '0;
        tick();
        chk("t6_trig", irq_trigger, 4'b1011);
        tick();
        src_trigger = 8'h40;
        tick();
        src_trigger = '0;
        chk("t6_service", busy, 4'b1011);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_busy", busy, 4'h0);
        chk("t6_async_trig", irq_trigger, 4'h0);
        chk("t6_async_pc", irq_pc, 128'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_post_trig", irq_trigger, 4'h0);
        chk("t6_post_busy", busy, 4'h0);
        src_trigger = 8'h80; set_pc(7, 32'h700);
        tick();
        src_trigger = '0;
        tick();
        chk("t6_new_trig", irq_trigger, 4'hF);
        chk("t6_new_src", irq_src, 12'hFFF);
        chk("t6_new_pc", irq_pc, {4{32'h700}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
